// File: rtl/frequency_pkg.sv
// frequency_pkg: constants and state encodings shared by frequency_generator and frequency_counter
package frequency_pkg;

    localparam int EDGE_BITS = 7;
    localparam logic [EDGE_BITS-1:0] MAX_EDGES = 7'd99;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'b00,
        STATE_RUN  = 2'b01
    } state_e;

endpackage

// File: rtl/edge_accumulator.sv
// edge_accumulator: spreads 2N toggles evenly over a W-clock window and holds the square-wave flop
module edge_accumulator
    import frequency_pkg::*;
#(
    parameter int BITS = 12
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic [EDGE_BITS:0] step,
    input  logic [BITS:0]      w,
    output logic               signal
);

    logic [BITS:0] acc_q, acc_d, sum;
    logic          sig_q, sig_d, wrap;

    // Add the step and wrap against W; every wrap is one toggle, the boundary forces the last one low
    always_comb begin
        sum   = acc_q + {{(BITS-EDGE_BITS){1'b0}}, step};
        wrap  = sum >= w;
        acc_d = clear ? '0 : (wrap ? sum - w : sum);
        sig_d = !clear && (sig_q ^ wrap);
    end

    // Accumulator and toggle flop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            sig_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sig_q <= sig_d;
        end
    end

    assign signal = sig_q;

endmodule

// File: rtl/frequency_generator.sv
// frequency_generator: emits exactly N rising edges per (P+1)-clock window, parameters swapped only at window boundaries
module frequency_generator
    import frequency_pkg::*;
#(
    parameter int UPDATE_PERIOD = 1200,
    parameter int BITS          = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [BITS-1:0]      period,
    input  logic                 period_load,
    input  logic [EDGE_BITS-1:0] edges,
    input  logic                 edges_load,
    output logic                 signal,
    output logic                 window_start,
    output logic                 clamped
);

    logic                 rdy_q;
    logic [BITS-1:0]      period_sh_q, p_q, cnt_q, cnt_d, period_eff, half_d;
    logic [EDGE_BITS-1:0] edges_sh_q, n_q, n_d, edges_eff, lim_d;
    logic                 clamped_q, clamped_d, boundary;
    logic [BITS:0]        w, w_d;
    logic [EDGE_BITS:0]   step;
    state_e               state_q, state_d;

    // Clamp the incoming request (with same-cycle strobe bypass) to 99 and to one toggle per clock
    always_comb begin
        period_eff = period_load ? period : period_sh_q;
        edges_eff  = edges_load ? edges : edges_sh_q;
        w_d        = {1'b0, period_eff} + {{BITS{1'b0}}, 1'b1};
        half_d     = w_d[BITS:1];
        lim_d      = (half_d < {{(BITS-EDGE_BITS){1'b0}}, MAX_EDGES}) ? half_d[EDGE_BITS-1:0] : MAX_EDGES;
        n_d        = (edges_eff < lim_d) ? edges_eff : lim_d;
        clamped_d  = n_d != edges_eff;
        boundary   = rdy_q && (cnt_q == p_q);
        cnt_d      = boundary ? '0 : cnt_q + BITS'(1);
        w          = {1'b0, p_q} + {{BITS{1'b0}}, 1'b1};
        step       = (state_q == STATE_RUN) ? {n_q, 1'b0} : '0;
    end

    // Shadow registers follow the strobes; window counter and active set advance once out of reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q       <= 1'b0;
            period_sh_q <= BITS'(UPDATE_PERIOD);
            edges_sh_q  <= '0;
            p_q         <= BITS'(UPDATE_PERIOD);
            n_q         <= '0;
            clamped_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (period_load) period_sh_q <= period;
            if (edges_load) edges_sh_q <= edges;
            if (rdy_q) cnt_q <= cnt_d;
            if (boundary) begin
                p_q       <= period_eff;
                n_q       <= n_d;
                clamped_q <= clamped_d;
            end
        end
    end

    // Run state is decided only at the boundary from the newly loaded N
    always_comb begin
        state_d = state_q;
        case (state_q)
            STATE_IDLE, STATE_RUN: if (boundary) state_d = (n_d != '0) ? STATE_RUN : STATE_IDLE;
            default:               state_d = STATE_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= STATE_IDLE;
        else          state_q <= state_d;
    end

    edge_accumulator #(.BITS(BITS)) u_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (boundary),
        .step    (step),
        .w       (w),
        .signal  (signal)
    );

    assign window_start = rdy_q && (cnt_q == '0);
    assign clamped      = clamped_q;

endmodule

// File: tb/tb_frequency_generator.sv
// tb_frequency_generator: table-driven edge-count and waveform checks plus mid-window load and reset sequences
module tb_frequency_generator;

    localparam int BITS = 12;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [BITS-1:0] period = '0;
    logic            period_load = 1'b0;
    logic [6:0]      edges = '0;
    logic            edges_load = 1'b0;
    logic            signal, window_start, clamped;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int          p;
        int          e;
        int          rises;
        logic        cl;
        logic [31:0] pat;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    frequency_generator #(.UPDATE_PERIOD(1200), .BITS(BITS)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .period       (period),
        .period_load  (period_load),
        .edges        (edges),
        .edges_load   (edges_load),
        .signal       (signal),
        .window_start (window_start),
        .clamped      (clamped)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input int p, input int e);
        period      = BITS'(p);
        edges       = 7'(e);
        period_load = 1'b1;
        edges_load  = 1'b1;
        @(negedge clk);
        period_load = 1'b0;
        edges_load  = 1'b0;
    endtask

    task automatic wait_ws(input string name);
        int i = 0;
        while (window_start !== 1'b1 && i < 5000) begin
            @(negedge clk);
            i++;
        end
        if (window_start !== 1'b1) check({name, " window_start timeout"}, 0, 1);
    endtask

    // Call at the negedge of a window_start cycle; returns at the negedge of the next one
    task automatic measure(input string name, input int p, input int exp_rises, input logic exp_cl,
                           input logic [31:0] exp_pat, input int strobe_at, input int strobe_e);
        int          len = 0;
        int          rises = 0;
        logic        prev;
        logic        cl_ok = 1'b1;
        logic [31:0] pat = '0;
        check({name, " start low"}, {31'd0, signal}, 0);
        prev = signal;
        do begin
            if (len < 32) pat[len] = signal;
            if (signal && !prev) rises++;
            if (clamped !== exp_cl) cl_ok = 1'b0;
            prev = signal;
            if (len == strobe_at) begin
                edges      = 7'(strobe_e);
                edges_load = 1'b1;
            end
            @(negedge clk);
            edges_load = 1'b0;
            len++;
        end while (window_start !== 1'b1 && len < 5000);
        check({name, " window length"}, len, p + 1);
        check({name, " rising edges"}, rises, exp_rises);
        check({name, " clamped"}, {31'd0, cl_ok}, 1);
        if (p < 32) check({name, " waveform"}, pat, exp_pat);
    endtask

    initial begin
        vecs[0]  = '{p: 9,    e: 1,   rises: 1,  cl: 1'b0, pat: 32'h3E0};
        vecs[1]  = '{p: 9,    e: 2,   rises: 2,  cl: 1'b0, pat: 32'h318};
        vecs[2]  = '{p: 9,    e: 5,   rises: 5,  cl: 1'b0, pat: 32'h2AA};
        vecs[3]  = '{p: 9,    e: 7,   rises: 5,  cl: 1'b1, pat: 32'h2AA};
        vecs[4]  = '{p: 1,    e: 1,   rises: 1,  cl: 1'b0, pat: 32'h2};
        vecs[5]  = '{p: 0,    e: 3,   rises: 0,  cl: 1'b1, pat: 32'h0};
        vecs[6]  = '{p: 20,   e: 10,  rises: 10, cl: 1'b0, pat: 32'h155554};
        vecs[7]  = '{p: 1200, e: 120, rises: 99, cl: 1'b1, pat: 32'h0};
        vecs[8]  = '{p: 1200, e: 42,  rises: 42, cl: 1'b0, pat: 32'h0};
        vecs[9]  = '{p: 1200, e: 99,  rises: 99, cl: 1'b0, pat: 32'h0};
        vecs[10] = '{p: 1200, e: 0,   rises: 0,  cl: 1'b0, pat: 32'h0};
        vecs[11] = '{p: 9,    e: 0,   rises: 0,  cl: 1'b0, pat: 32'h0};

        repeat (3) @(negedge clk);
        check("reset signal", {31'd0, signal}, 0);
        check("reset window_start", {31'd0, window_start}, 0);
        check("reset clamped", {31'd0, clamped}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("first clock window_start", {31'd0, window_start}, 1);
        measure("reset window", 1200, 0, 1'b0, 32'h0, -1, 0);

        for (int i = 0; i < 12; i++) begin
            load(vecs[i].p, vecs[i].e);
            wait_ws($sformatf("vec%0d", i));
            measure($sformatf("vec%0d", i), vecs[i].p, vecs[i].rises, vecs[i].cl, vecs[i].pat, -1, 0);
        end

        load(9, 1);
        wait_ws("midload");
        measure("midload cur", 9, 1, 1'b0, 32'h3E0, -1, 0);
        measure("midload strobe", 9, 1, 1'b0, 32'h3E0, 4, 3);
        measure("boundary strobe", 9, 3, 1'b0, 32'h26C, 9, 2);
        measure("bypassed", 9, 2, 1'b0, 32'h318, -1, 0);

        load(9, 1);
        wait_ws("prereset");
        repeat (6) @(negedge clk);
        check("signal high cnt6", {31'd0, signal}, 1);
        reset_n = 1'b0;
        #1;
        check("async reset signal", {31'd0, signal}, 0);
        check("async reset window_start", {31'd0, window_start}, 0);
        check("async reset clamped", {31'd0, clamped}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post reset window_start", {31'd0, window_start}, 1);
        measure("post reset win1", 1200, 0, 1'b0, 32'h0, -1, 0);
        measure("post reset win2", 1200, 0, 1'b0, 32'h0, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frequency_generator.md
# frequency_generator

Programmable square-wave source, the transmit-side companion of `frequency_counter`. Each measurement window is `update_period + 1` clocks long. In every window the block emits exactly N rising edges on `signal`, spaced as evenly as integer arithmetic allows. It drives bench and on-chip loopback stimulus for the counter, so the counter's two-digit display can be checked against a known edge count.

## Interface
Parameters:
- `UPDATE_PERIOD`, 1200: reset value of the window period register.
- `BITS`, 12: width of the period register and the window counter.

Ports:
- `clk`  in  1: single clock.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `period`  in  BITS: new window period P. The window is P+1 clocks.
- `period_load`  in  1: one-cycle strobe that captures `period` into the shadow register.
- `edges`  in  7: requested rising edges per window.
- `edges_load`  in  1: one-cycle strobe that captures `edges` into the shadow register.
- `signal`  out  1: generated square wave, registered.
- `window_start`  out  1: high during the first cycle of each window (window counter = 0).
- `clamped`  out  1: high for the whole window when the active N is less than the requested `edges`.

## Operation
- Shadow registers:
  - `period_sh` resets to UPDATE_PERIOD; `edges_sh` resets to 0.
  - A load strobe overwrites its shadow register.
- Active registers `P` and `N`:
  - They copy the shadows only at a window boundary, so a window never changes its parameters mid-way.
  - A strobe asserted during the boundary cycle is bypassed straight into the new window.
- Clamp rule: N = min(`edges_sh`, 99, (P+1)>>1).
  - This guarantees at most one toggle per clock.
  - `clamped` is registered together with N.
- Window counter `cnt` runs 0..P.
- Toggle accumulator, BITS+1 bits wide, with W = P+1:
  - On each cycle where cnt < P: `acc_next = acc + 2N`.
  - If `acc_next >= W`, subtract W and toggle `signal`.
- Boundary cycle (cnt == P):
  - `cnt`←0, `acc`←0, `signal`←0, active registers reload.
  - The forced low is the 2N-th toggle, so every window starts and ends low and contains exactly N rising edges.
- FSM:
  - STATE_IDLE: N == 0. `signal` is held low; `cnt` and `window_start` keep running.
  - STATE_RUN: N > 0.
  - The state is re-evaluated only at the boundary from the newly loaded N.
  - An undefined state encoding goes to STATE_IDLE.

## Timing
- Reset (asynchronous assert, synchronous deassert at the next clk edge) sets:
  - `signal`=0, `window_start`=0, `clamped`=0, `cnt`=0, `acc`=0, state IDLE.
  - P=UPDATE_PERIOD, N=0.
- First clock after reset release: cnt=0 and `window_start` is high.
- Load latency: a parameter change appears in the window that begins after the boundary following the strobe, i.e. at most P+1 clocks later.
- Rising-edge position: the k-th toggle is registered at the end of the cycle where cnt reaches the smallest c with (c+1)·2N ≥ k·W. `signal` changes on the following cycle.
- P = 0 (W = 1): N clamps to 0, `signal` stays low, `window_start` is high every cycle, and `clamped` is set if `edges_sh` > 0.
- 2N = W: `signal` toggles every clock, a divide-by-2 of `clk`.
- `edges` > 99: N = 99 and `clamped` = 1.
- Reset asserted mid-window: all outputs go low immediately; the loaded shadows return to their reset values.

## Structure
- Shared package `frequency_pkg` holds:
  - `MAX_EDGES` = 99 and `EDGE_BITS` = 7. These are shared with `frequency_counter`.
  - State encodings STATE_IDLE and STATE_RUN.
- One sub-module, `edge_accumulator`, contains the accumulator, the compare/subtract against W, and the toggle flop. Its inputs are the step 2N, W, and a synchronous clear.
- Window counter, shadow and active registers, clamp logic and FSM stay at top level.

## Test plan
- Reset, then P=9 via `period_load`, `edges`=1 via `edges_load`, then wait one boundary. In each 10-cycle window `signal` is low for cnt 0–4 and high for cnt 5–9: one rising edge, 50% duty.
- P=9, `edges`=5 → `signal` toggles every clock, 5 rising edges per window, `clamped`=0. Then `edges`=7 → still 5 edges and `clamped`=1 from the next window on.
- `edges`=120 with P=1200 → 99 rising edges per 1201-clock window and `clamped`=1.
- Loads mid-window: strobe `edges`=3 at cnt=4 of a P=9 window running N=1. The current window still has 1 edge, the next has 3, and the boundary-cycle bypass is exercised. Separately, `edges`=0 → IDLE with `signal` constantly low.
- Drive `reset_n` low at cnt=6 while `signal` is high. `signal` drops without waiting for a clock edge. After release: `window_start` is high on the first clock, P=1200, N=0.
- Loopback into `frequency_counter` (P=1200 on both, `edges`=42) → the display decodes to 42 ±1 on every update. Repeat for 0, 9, 10, 99.
